// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_pkg
//  Description : Shared constants and helpers for the prio_enc_rr encoder:
//                arbitration mode encoding and modulo-N pointer decrement.
//  Revision    : 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

    // Arbitration mode encoding on the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Step an index one place down the priority ring. Index 0 wraps to n-1,
    // never to 2^W-1, so non-power-of-two widths stay inside 0..n-1.
    function automatic int dec_mod(input int value, input int n);
        return (value == 0) ? (n - 1) : (value - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_rr_if
//  Description : Request/grant bundle of the prio_enc_rr encoder. The master
//                side drives requests, enable, mode and ack; the slave side
//                (the encoder) returns the 148-style code and status pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prio_enc_rr_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic           ei_n;
    logic [N-1:0]   req_n;
    logic           mode;
    logic           ack;
    logic [W-1:0]   code_n;
    logic           gs_n;
    logic           eo_n;
    logic           valid;

    modport master (
        output ei_n, req_n, mode, ack,
        input  code_n, gs_n, eo_n, valid
    );

    modport slave (
        input  ei_n, req_n, mode, ack,
        output code_n, gs_n, eo_n, valid
    );

endinterface
`default_nettype wire

// File: rtl/prio_enc_core.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_core
//  Description : Combinational priority search. Starting at i_start, walks
//                downward through the active-high request vector, wrapping
//                from 0 to N-1, and reports the first active index.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_core #(
    parameter int N = 8
) (
    input  wire logic [N-1:0]           i_req,
    input  wire logic [$clog2(N)-1:0]   i_start,
    output logic                        o_found,
    output logic [$clog2(N)-1:0]        o_idx
);
    localparam int W = $clog2(N);

    // Downward ring search; the first hit wins, later hits are ignored.
    always_comb begin
        int             w_cand;
        logic [W-1:0]   w_cand_idx;
        o_found    = 1'b0;
        o_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(i_start) - k;
            if (w_cand < 0) begin
                w_cand = w_cand + N;
            end
            w_cand_idx = W'(w_cand);
            if (!o_found && i_req[w_cand_idx]) begin
                o_found = 1'b1;
                o_idx   = w_cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prio_enc_rr.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_rr
//  Description : N-input active-low priority encoder with registered outputs,
//                fixed or round-robin arbitration, a grant lock released by
//                ack (or by the granted request dropping), and 74HC148-style
//                cascade pins (ei_n / eo_n / gs_n).
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    prio_enc_rr_if.slave    enc_bus
);
    localparam int          W         = $clog2(N);
    localparam logic [W-1:0] C_TOP_IDX = W'(N - 1);

    logic [W-1:0]   r_idx;
    logic [W-1:0]   r_ptr;
    logic           r_valid;
    logic           r_eo_n;

    logic [N-1:0]   w_req;
    logic           w_any;
    logic           w_hold;
    logic           w_accept;
    logic [W-1:0]   w_ptr_nxt;
    logic [W-1:0]   w_start;
    logic           w_found;
    logic [W-1:0]   w_win;

    assign w_req    = ~enc_bus.req_n;
    assign w_any    = |w_req;

    // The lock survives only while unacknowledged and still requested.
    assign w_hold   = r_valid & ~enc_bus.ack & w_req[r_idx];
    assign w_accept = r_valid & enc_bus.ack;

    // Pointer moves below the serviced index on an accepted RR grant; the
    // fresh arbitration in the same cycle already uses the moved pointer,
    // which gives back-to-back grants with no bubble.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_start   = C_TOP_IDX;
        if (w_accept && (enc_bus.mode == MODE_RR)) begin
            w_ptr_nxt = W'(dec_mod(int'(r_idx), N));
        end
        if (enc_bus.mode == MODE_RR) begin
            w_start = w_ptr_nxt;
        end
    end

    prio_enc_core #(
        .N (N)
    ) u_core (
        .i_req   (w_req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    // Lock, pointer and output registers; disable drops the lock but keeps ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_eo_n  <= 1'b1;
            r_ptr   <= C_TOP_IDX;
        end else if (enc_bus.ei_n) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_eo_n  <= 1'b1;
        end else begin
            r_eo_n  <= w_any;
            r_ptr   <= w_ptr_nxt;
            if (!w_hold) begin
                r_valid <= w_found;
                r_idx   <= w_found ? w_win : '0;
            end
        end
    end

    // Index 0 and "no grant" both read as all ones, as on the 148.
    assign enc_bus.code_n = ~r_idx;
    assign enc_bus.gs_n   = ~r_valid;
    assign enc_bus.valid  = r_valid;
    assign enc_bus.eo_n   = r_eo_n;

endmodule
`default_nettype wire
